seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//   Session controller for the serial pattern detector. Accepts parallel words over a valid/ready
//   handshake, serialises them MSB-first into an internal PAT_LEN-bit pattern matcher, counts
//   (overlapping) matches over a session opened by start and closed by the word tagged last.
//   It flags when a programmable match threshold is reached.
// PARAMETERS
//   DATA_W   8          width of input word; bits shifted per accepted word
//   PAT_LEN  6          pattern length in bits (2..DATA_W*4)
//   PATTERN  6'b101110  target pattern; PATTERN[PAT_LEN-1] is the first-arriving bit
//   CNT_W    8          width of match counter and threshold
// PORTS
//   clk        in   1       clock, all logic on rising edge
//   rst_n      in   1       reset, synchronous, active-low
//   start      in   1       open session (honoured only in IDLE)
//   cfg_thresh in   CNT_W   hit threshold, latched on accepted start; 0 = disabled
//   in_valid   in   1       input word valid
//   in_ready   out  1       controller can accept a word
//   in_data    in   DATA_W  input word, MSB shifted first
//   in_last    in   1       word is the final word of the session
//   busy       out  1       high in every state except IDLE
//   det_pulse  out  1       one-cycle pulse per pattern match
//   match_cnt  out  CNT_W   matches counted this session, saturating
//   hit        out  1       sticky: match_cnt >= latched threshold (threshold != 0)
//   done       out  1       one-cycle pulse at session end
// BEHAVIOUR
// - Reset (rst_n low at a rising edge): state IDLE.
//   - All outputs 0; history, bit-fill counter and latched threshold cleared.
//   - Applies from any state, including mid-word; the partially shifted word is discarded.
// - FSM: IDLE -> WAIT -> SHIFT -> (WAIT | DONE) -> IDLE.
//   - IDLE: in_ready=0. start=1 -> clear match_cnt, hit, history and fill counter; latch cfg_thresh; go to WAIT.
//   - WAIT: in_ready=1 (registered output, high for the whole state).
//     - in_valid & in_ready at cycle T -> capture in_data and in_last; go to SHIFT.
//     - in_valid=0 -> stay in WAIT indefinitely (no timeout).
//   - SHIFT: exactly DATA_W cycles, in_ready=0. Bit i (i=0 is the MSB) is consumed in cycle T+1+i.
//     - history <= {history[PAT_LEN-2:0], bit}.
//     - Fill counter increments, saturating at PAT_LEN.
//     - After the last bit: captured last=1 -> DONE, else -> WAIT.
//       Back-to-back words are therefore accepted no faster than one per DATA_W+1 cycles.
//   - DONE: done=1 for exactly one cycle, busy=1; then IDLE.
//     - match_cnt and hit hold their values until the next accepted start.
// - Match: evaluated on the updated history after each shift; requires fill == PAT_LEN.
//   - det_pulse is registered: high in cycle T+2+i when bit i completes the pattern.
//   - match_cnt increments on the same edge.
//   - Overlapping matches count. History persists across word boundaries within a session.
// - Timing of the last bit: a match on the last bit of the last word raises det_pulse in the same
//   cycle as done, and match_cnt already includes it.
// - Counter: saturates at 2^CNT_W-1; det_pulse still pulses after saturation.
// - hit: set on the edge where the new match_cnt >= threshold and threshold != 0; sticky until next start.
// - start while busy is ignored. start=1 in IDLE is accepted even if in_valid=1 in the same cycle;
//   that word is taken only from WAIT.
// - in_data and in_last are sampled only on the handshake cycle; changes outside it are ignored.
// TESTING
// 1. Single word: start, thresh=1, word 8'b10111000 last=1 at T.
//    -> det_pulse at T+7 only; done at T+9; match_cnt=1; hit=1.
// 2. Cross-word: words 8'b00001011, then 8'b10000000 last=1.
//    -> exactly one det_pulse, during the second word's shift (its bit 1); final match_cnt=1.
// 3. Overlap and saturation: CNT_W=2, stream containing 5 pattern occurrences.
//    -> det_pulse x5; match_cnt sticks at 3.
//    Also: thresh=0 -> hit stays 0.
// 4. Handshake: hold in_valid=0 for 20 cycles in WAIT.
//    -> in_ready stays 1, busy=1, no shifting.
//    Also: assert in_valid during SHIFT -> in_ready=0; that word is not taken until the state returns to WAIT.
// 5. Reset mid-SHIFT: drop rst_n at bit 4 of a matching word.
//    -> next cycle IDLE with all outputs 0; a new session starting from 8'b00101110
//       gives no match from stale history.
// 6. start while busy: pulse start during SHIFT with a different cfg_thresh.
//    -> ignored; the threshold and count of the original session are unchanged.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: session controller serialising handshaked words MSB-first into a pattern matcher with match counting
module seq_detect_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_LEN = 6,
  parameter logic [PAT_LEN-1:0] PATTERN = 6'b101110,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              busy,
  output logic              det_pulse,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              hit,
  output logic              done
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int FW = $clog2(PAT_LEN + 1);
  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] sreg;
  logic last_q;
  logic [BW-1:0] bit_cnt;
  logic [PAT_LEN-1:0] hist, hist_nxt;
  logic [FW-1:0] fill, fill_nxt;
  logic [CNT_W-1:0] thresh, cnt_nxt;
  logic match, last_bit;
  always_comb begin
    hist_nxt = PAT_LEN'({hist, sreg[DATA_W-1]});
    fill_nxt = fill == FW'(PAT_LEN) ? fill : fill + 1'b1;
    match = hist_nxt == PATTERN && fill_nxt == FW'(PAT_LEN);
    cnt_nxt = &match_cnt ? match_cnt : match_cnt + 1'b1;
    last_bit = bit_cnt == BW'(DATA_W - 1);
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = start ? WAIT : IDLE;
      WAIT:  state_nxt = in_valid ? SHIFT : WAIT;
      SHIFT: state_nxt = !last_bit ? SHIFT : last_q ? DONE : WAIT;
      DONE:  state_nxt = IDLE;
    endcase
  end
  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      det_pulse <= 1'b0;
      match_cnt <= '0;
      hit <= 1'b0;
      sreg <= '0;
      last_q <= 1'b0;
      bit_cnt <= '0;
      hist <= '0;
      fill <= '0;
      thresh <= '0;
    end else begin
      state <= state_nxt;
      in_ready <= state_nxt == WAIT;
      busy <= state_nxt != IDLE;
      done <= state_nxt == DONE;
      det_pulse <= 1'b0;
      if (state == IDLE && start) begin
        match_cnt <= '0;
        hit <= 1'b0;
        hist <= '0;
        fill <= '0;
        thresh <= cfg_thresh;
      end
      if (state == WAIT && in_valid) begin
        sreg <= in_data;
        last_q <= in_last;
        bit_cnt <= '0;
      end
      if (state == SHIFT) begin
        sreg <= sreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
        hist <= hist_nxt;
        fill <= fill_nxt;
        det_pulse <= match;
        if (match) begin
          match_cnt <= cnt_nxt;
          if (thresh != '0 && cnt_nxt >= thresh) hit <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed checks of the pattern-detect session controller (8-bit and 2-bit counter builds)
module tb_seq_detect_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_last;
  logic [7:0] cfg_thresh, in_data;
  logic rdy8, busy8, det8, hit8, done8;
  logic [7:0] cnt8;
  logic rdy2, busy2, det2, hit2, done2;
  logic [1:0] cnt2;
  int tests = 0, fails = 0;
  int cyc = 0, det_n = 0, det2_n = 0, det_cyc = -1, done_cyc = -1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (det8) begin det_n++; det_cyc = cyc; end
    if (det2) det2_n++;
    if (done8) done_cyc = cyc;
  end
  seq_detect_ctrl dut8 (.clk(clk), .rst_n(rst_n), .start(start), .cfg_thresh(cfg_thresh),
    .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data), .in_last(in_last), .busy(busy8),
    .det_pulse(det8), .match_cnt(cnt8), .hit(hit8), .done(done8));
  seq_detect_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start), .cfg_thresh(cfg_thresh[1:0]),
    .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data), .in_last(in_last), .busy(busy2),
    .det_pulse(det2), .match_cnt(cnt2), .hit(hit2), .done(done2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_mon();
    det_n = 0; det2_n = 0; det_cyc = -1; done_cyc = -1;
  endtask
  task automatic open_session(input logic [7:0] th);
    clear_mon();
    start = 1'b1; cfg_thresh = th;
    tick();
    start = 1'b0; cfg_thresh = 8'hA5;
  endtask
  task automatic send_word(input logic [7:0] d, input logic l, output int t);
    for (int i = 0; i < 100 && !rdy8; i++) tick();
    tests++;
    if (rdy8 !== 1'b1) begin fails++; $display("FAIL ready_timeout in_ready=%b want 1", rdy8); end
    in_valid = 1'b1; in_data = d; in_last = l; t = cyc;
    tick();
    in_valid = 1'b0; in_data = ~d; in_last = ~l;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 200 && !done8; i++) tick();
    tests++;
    if (done8 !== 1'b1) begin fails++; $display("FAIL done_timeout done=%b want 1", done8); end
    tick();
  endtask
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; cfg_thresh = '0;
    tick(); tick();
    tests++;
    if ({rdy8, busy8, det8, cnt8, hit8, done8} !== 13'd0) begin fails++;
      $display("FAIL reset_out got %b want 0", {rdy8, busy8, det8, cnt8, hit8, done8}); end
    tests++;
    if ({rdy2, busy2, det2, cnt2, hit2, done2} !== 7'd0) begin fails++;
      $display("FAIL reset_out2 got %b want 0", {rdy2, busy2, det2, cnt2, hit2, done2}); end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_single_word();
    int t;
    open_session(8'd1);
    send_word(8'b10111000, 1'b1, t);
    wait_done();
    tests++; if (det_n !== 1) begin fails++; $display("FAIL single_det_n got %0d want 1", det_n); end
    tests++; if (det_cyc !== t + 7) begin fails++; $display("FAIL single_det_cyc got %0d want %0d", det_cyc, t + 7); end
    tests++; if (done_cyc !== t + 9) begin fails++; $display("FAIL single_done_cyc got %0d want %0d", done_cyc, t + 9); end
    tests++; if (cnt8 !== 8'd1) begin fails++; $display("FAIL single_cnt got %0d want 1", cnt8); end
    tests++; if (hit8 !== 1'b1) begin fails++; $display("FAIL single_hit got %b want 1", hit8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b want 0", busy8); end
  endtask
  task automatic test_cross_word();
    int t1, t2;
    open_session(8'd0);
    send_word(8'b00001011, 1'b0, t1);
    send_word(8'b10000000, 1'b1, t2);
    wait_done();
    tests++; if (det_n !== 1) begin fails++; $display("FAIL cross_det_n got %0d want 1", det_n); end
    tests++; if (det_cyc !== t2 + 3) begin fails++; $display("FAIL cross_det_cyc got %0d want %0d", det_cyc, t2 + 3); end
    tests++; if (cnt8 !== 8'd1) begin fails++; $display("FAIL cross_cnt got %0d want 1", cnt8); end
    tests++; if (hit8 !== 1'b0) begin fails++; $display("FAIL cross_hit got %b want 0", hit8); end
  endtask
  task automatic test_overlap_sat();
    int t;
    open_session(8'd0);
    send_word(8'b00101110, 1'b0, t);
    send_word(8'b11101110, 1'b0, t);
    send_word(8'b11101110, 1'b1, t);
    wait_done();
    tests++; if (det_n !== 5) begin fails++; $display("FAIL ovl_det_n got %0d want 5", det_n); end
    tests++; if (det2_n !== 5) begin fails++; $display("FAIL ovl_det2_n got %0d want 5", det2_n); end
    tests++; if (cnt8 !== 8'd5) begin fails++; $display("FAIL ovl_cnt got %0d want 5", cnt8); end
    tests++; if (cnt2 !== 2'd3) begin fails++; $display("FAIL sat_cnt2 got %0d want 3", cnt2); end
    tests++; if ({hit8, hit2} !== 2'b00) begin fails++; $display("FAIL thresh0_hit got %b want 00", {hit8, hit2}); end
  endtask
  task automatic test_handshake();
    int t1, t2;
    open_session(8'd0);
    for (int i = 0; i < 20; i++) begin
      tests++;
      if ({rdy8, busy8} !== 2'b11) begin fails++; $display("FAIL wait_hold rdy,busy got %b want 11", {rdy8, busy8}); end
      tick();
    end
    tests++; if (det_n !== 0) begin fails++; $display("FAIL wait_no_det got %0d want 0", det_n); end
    send_word(8'hFF, 1'b0, t1);
    in_valid = 1'b1; in_data = 8'b10111000; in_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rdy8 !== 1'b0) begin fails++; $display("FAIL shift_ready got %b want 0", rdy8); end
      tick();
    end
    tests++;
    if (rdy8 !== 1'b1 || cyc !== t1 + 9) begin fails++;
      $display("FAIL rewait ready=%b cyc=%0d want 1 at %0d", rdy8, cyc, t1 + 9); end
    t2 = cyc;
    tick();
    in_valid = 1'b0;
    wait_done();
    tests++; if (det_n !== 1) begin fails++; $display("FAIL hs_det_n got %0d want 1", det_n); end
    tests++; if (det_cyc !== t2 + 7) begin fails++; $display("FAIL hs_det_cyc got %0d want %0d", det_cyc, t2 + 7); end
  endtask
  task automatic test_reset_mid_shift();
    int t;
    open_session(8'd1);
    send_word(8'b10111000, 1'b1, t);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({rdy8, busy8, det8, cnt8, hit8, done8} !== 13'd0) begin fails++;
      $display("FAIL midrst_out got %b want 0", {rdy8, busy8, det8, cnt8, hit8, done8}); end
    open_session(8'd0);
    send_word(8'b00101110, 1'b1, t);
    wait_done();
    tests++; if (det_n !== 1) begin fails++; $display("FAIL midrst_det_n got %0d want 1", det_n); end
    tests++; if (det_cyc !== t + 9) begin fails++; $display("FAIL midrst_det_cyc got %0d want %0d", det_cyc, t + 9); end
    tests++; if (cnt8 !== 8'd1) begin fails++; $display("FAIL midrst_cnt got %0d want 1", cnt8); end
  endtask
  task automatic test_start_busy();
    int t;
    open_session(8'd2);
    send_word(8'b10111000, 1'b0, t);
    start = 1'b1; cfg_thresh = 8'd1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    tests++;
    if ({busy8, cnt8, hit8} !== {1'b1, 8'd1, 1'b0}) begin fails++;
      $display("FAIL busy_start mid busy,cnt,hit got %b,%0d,%b want 1,1,0", busy8, cnt8, hit8); end
    send_word(8'b10111000, 1'b1, t);
    wait_done();
    tests++; if (cnt8 !== 8'd2) begin fails++; $display("FAIL busy_start_cnt got %0d want 2", cnt8); end
    tests++; if ({hit8, hit2} !== 2'b11) begin fails++; $display("FAIL busy_start_hit got %b want 11", {hit8, hit2}); end
  endtask
  initial begin
    test_reset();
    test_single_word();
    test_cross_word();
    test_overlap_sat();
    test_handshake();
    test_reset_mid_shift();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
